// File: rtl/ra_stack_spec.sv
// Speculative circular return-address stack for the fetch predictor.
// Per-branch checkpoints feed back through restore to undo wrong-path updates.
module ra_stack_spec #(
  parameter int ADDR     = 32,
  parameter int RA_DEPTH = 8,
  parameter int INCR     = 4,
  parameter int PTRW     = $clog2(RA_DEPTH),
  parameter int CNTW     = $clog2(RA_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_v,
  input  logic [ADDR-1:0] push_pc,
  input  logic            pop_v,
  output logic            ret_v,
  output logic [ADDR-1:0] ret_addr,
  output logic [PTRW-1:0] ckpt_ptr,
  output logic [CNTW-1:0] ckpt_cnt,
  output logic [ADDR-1:0] ckpt_top,
  input  logic            restore_v,
  input  logic [PTRW-1:0] restore_ptr,
  input  logic [CNTW-1:0] restore_cnt,
  input  logic [ADDR-1:0] restore_top,
  output logic            ovf,
  output logic            udf
);

  logic [ADDR-1:0] mem_q [RA_DEPTH];
  logic [PTRW-1:0] tos_q, tos_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            wr_en;
  logic [PTRW-1:0] wr_idx;
  logic [ADDR-1:0] ret_pc;
  logic            empty, full;

  assign ret_pc = push_pc + ADDR'(INCR);
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNTW'(RA_DEPTH));

  always_comb begin
    tos_d  = tos_q;
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = tos_q;
    if (push_v && (!pop_v || empty)) begin
      // Wrapping onto the oldest slot is what evicts it when full.
      tos_d  = tos_q + PTRW'(1);
      cnt_d  = full ? cnt_q : cnt_q + CNTW'(1);
      ovf_d  = full;
      wr_en  = 1'b1;
      wr_idx = tos_q + PTRW'(1);
    end else if (push_v && pop_v) begin
      wr_en  = 1'b1;
    end else if (pop_v) begin
      if (empty) begin
        udf_d = 1'b1;
      end else begin
        tos_d = tos_q - PTRW'(1);
        cnt_d = cnt_q - CNTW'(1);
      end
    end
  end

  assign ckpt_ptr = tos_d;
  assign ckpt_cnt = cnt_d;

  always_comb begin
    ckpt_top = '0;
    if (cnt_d != '0) begin
      ckpt_top = wr_en ? ret_pc : mem_q[tos_d];
    end
  end

  assign ret_v    = !empty;
  assign ret_addr = ret_v ? mem_q[tos_q] : '0;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (restore_v) begin
      tos_q <= restore_ptr;
      cnt_q <= restore_cnt;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Entries are never cleared; cnt alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (restore_v) begin
        mem_q[restore_ptr] <= restore_top;
      end else if (wr_en) begin
        mem_q[wr_idx] <= ret_pc;
      end
    end
  end

endmodule

// File: tb/tb_ra_stack_spec.sv
// Scoreboard bench for ra_stack_spec at depth 4.
// Expected state is queued at drive time and checked after the edge.
module tb_ra_stack_spec;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_v;
  logic [31:0] push_pc;
  logic        pop_v;
  logic        ret_v;
  logic [31:0] ret_addr;
  logic [1:0]  ckpt_ptr;
  logic [2:0]  ckpt_cnt;
  logic [31:0] ckpt_top;
  logic        restore_v;
  logic [1:0]  restore_ptr;
  logic [2:0]  restore_cnt;
  logic [31:0] restore_top;
  logic        ovf;
  logic        udf;

  int n_tests = 0;
  int n_fail  = 0;
  int step_id = 0;

  typedef struct {
    int          id;
    logic        v;
    logic [31:0] a;
    logic [2:0]  c;
    logic        o;
    logic        u;
  } exp_t;

  exp_t sb[$];

  ra_stack_spec #(.RA_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .push_v      (push_v),
    .push_pc     (push_pc),
    .pop_v       (pop_v),
    .ret_v       (ret_v),
    .ret_addr    (ret_addr),
    .ckpt_ptr    (ckpt_ptr),
    .ckpt_cnt    (ckpt_cnt),
    .ckpt_top    (ckpt_top),
    .restore_v   (restore_v),
    .restore_ptr (restore_ptr),
    .restore_cnt (restore_cnt),
    .restore_top (restore_top),
    .ovf         (ovf),
    .udf         (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    reset       = 1'b0;
    push_v      = 1'b0;
    push_pc     = '0;
    pop_v       = 1'b0;
    restore_v   = 1'b0;
    restore_ptr = '0;
    restore_cnt = '0;
    restore_top = '0;
  endtask

  task automatic drive(input logic rs, input logic pu, input logic [31:0] pc,
                       input logic po);
    idle_in();
    reset   = rs;
    push_v  = pu;
    push_pc = pc;
    pop_v   = po;
  endtask

  // Queue expectation, clock once, idle inputs so ckpt_cnt shows cnt.
  task automatic cycle(input logic ev, input logic [31:0] ea,
                       input logic [2:0] ec, input logic eo, input logic eu);
    exp_t e;
    exp_t g;
    step_id++;
    e.id = step_id;
    e.v  = ev;
    e.a  = ea;
    e.c  = ec;
    e.o  = eo;
    e.u  = eu;
    sb.push_back(e);
    @(posedge clk);
    #1 idle_in();
    #1;
    g = sb.pop_front();
    chk($sformatf("s%0d_v", g.id), 32'(ret_v), 32'(g.v));
    chk($sformatf("s%0d_addr", g.id), ret_addr, g.a);
    chk($sformatf("s%0d_cnt", g.id), 32'(ckpt_cnt), 32'(g.c));
    chk($sformatf("s%0d_ovf", g.id), 32'(ovf), 32'(g.o));
    chk($sformatf("s%0d_udf", g.id), 32'(udf), 32'(g.u));
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ea,
                      input logic [2:0] ec, input logic eo);
    drive(1'b0, 1'b1, pc, 1'b0);
    cycle(1'b1, ea, ec, eo, 1'b0);
  endtask

  task automatic pop(input logic ev, input logic [31:0] ea,
                     input logic [2:0] ec, input logic eu);
    drive(1'b0, 1'b0, '0, 1'b1);
    cycle(ev, ea, ec, 1'b0, eu);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  logic [1:0]  cap_ptr;
  logic [2:0]  cap_cnt;
  logic [31:0] cap_top;

  initial begin
    idle_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    do_reset();

    // basic LIFO
    push(32'h100, 32'h104, 3'd1, 1'b0);
    push(32'h200, 32'h204, 3'd2, 1'b0);
    pop(1'b1, 32'h104, 3'd1, 1'b0);
    pop(1'b0, 32'h0, 3'd0, 1'b0);

    // overflow then underflow
    push(32'h10, 32'h14, 3'd1, 1'b0);
    push(32'h20, 32'h24, 3'd2, 1'b0);
    push(32'h30, 32'h34, 3'd3, 1'b0);
    push(32'h40, 32'h44, 3'd4, 1'b0);
    push(32'h50, 32'h54, 3'd4, 1'b1);
    pop(1'b1, 32'h44, 3'd3, 1'b0);
    pop(1'b1, 32'h34, 3'd2, 1'b0);
    pop(1'b1, 32'h24, 3'd1, 1'b0);
    pop(1'b0, 32'h0, 3'd0, 1'b0);
    pop(1'b0, 32'h0, 3'd0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);

    // simultaneous push and pop
    push(32'h100, 32'h104, 3'd1, 1'b0);
    push(32'h200, 32'h204, 3'd2, 1'b0);
    drive(1'b0, 1'b1, 32'h300, 1'b1);
    cycle(1'b1, 32'h304, 3'd2, 1'b0, 1'b0);
    pop(1'b1, 32'h104, 3'd1, 1'b0);
    pop(1'b0, 32'h0, 3'd0, 1'b0);
    drive(1'b0, 1'b1, 32'h700, 1'b1);
    cycle(1'b1, 32'h704, 3'd1, 1'b0, 1'b0);
    pop(1'b0, 32'h0, 3'd0, 1'b0);

    // carry out of push_pc+INCR is dropped
    push(32'hFFFF_FFFE, 32'h2, 3'd1, 1'b0);
    pop(1'b0, 32'h0, 3'd0, 1'b0);

    // checkpoint and restore
    do_reset();
    drive(1'b0, 1'b1, 32'h100, 1'b0);
    #1;
    chk("ckpt_ptr", 32'(ckpt_ptr), 32'd1);
    chk("ckpt_cnt", 32'(ckpt_cnt), 32'd1);
    chk("ckpt_top", ckpt_top, 32'h104);
    cap_ptr = ckpt_ptr;
    cap_cnt = ckpt_cnt;
    cap_top = ckpt_top;
    cycle(1'b1, 32'h104, 3'd1, 1'b0, 1'b0);
    pop(1'b0, 32'h0, 3'd0, 1'b0);
    push(32'h500, 32'h504, 3'd1, 1'b0);
    push(32'h600, 32'h604, 3'd2, 1'b0);
    idle_in();
    restore_v   = 1'b1;
    restore_ptr = cap_ptr;
    restore_cnt = cap_cnt;
    restore_top = cap_top;
    cycle(1'b1, 32'h104, 3'd1, 1'b0, 1'b0);
    pop(1'b0, 32'h0, 3'd0, 1'b0);

    // restore beats push/pop on a full stack
    do_reset();
    push(32'h10, 32'h14, 3'd1, 1'b0);
    push(32'h20, 32'h24, 3'd2, 1'b0);
    push(32'h30, 32'h34, 3'd3, 1'b0);
    push(32'h40, 32'h44, 3'd4, 1'b0);
    drive(1'b0, 1'b1, 32'h999, 1'b1);
    restore_v   = 1'b1;
    restore_ptr = 2'd2;
    restore_cnt = 3'd3;
    restore_top = 32'hABC;
    cycle(1'b1, 32'hABC, 3'd3, 1'b0, 1'b0);
    chk("rst_prio_ptr", 32'(ckpt_ptr), 32'd2);
    pop(1'b1, 32'h14, 3'd2, 1'b0);

    // reset mid-stream with a push pending
    push(32'h1000, 32'h1004, 3'd3, 1'b0);
    push(32'h2000, 32'h2004, 3'd4, 1'b0);
    push(32'h3000, 32'h3004, 3'd4, 1'b1);
    drive(1'b1, 1'b1, 32'h900, 1'b0);
    cycle(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    push(32'h80, 32'h84, 3'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
